// File: rtl/chan_pkg.sv
// Shared constants and helpers for the parity receive channel.
package chan_pkg;

   localparam int PAR_EVEN   = 0;
   localparam int PAR_ODD    = 1;
   localparam int DEF_DATA_W = 9;

   // Increment that sticks at the all-ones value of a counter 'width' bits wide.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= max_val) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/parity_rx_channel_if.sv
// Receive strobe/word input and valid/ready output handshake of the parity channel.
interface parity_rx_channel_if #(
   parameter int DATA_W = chan_pkg::DEF_DATA_W
);
   logic              rx_stb;
   logic [DATA_W:0]   rx_word;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (
      output rx_stb, rx_word, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  rx_stb, rx_word, out_ready,
      output out_valid, out_data
   );
endinterface

// File: rtl/chan_fifo.sv
// Synchronous FIFO with a registered head word; the head register is refilled
// from storage (or straight from the push data) on every edge.
module chan_fifo import chan_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     clr_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DATA_W-1:0]        head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]     count_reg, count_next, remain;
   logic [DATA_W-1:0] head_reg, head_next;
   logic              push_ok, pop_ok;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign pop_ok  = pop && !empty;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign push_ok = push && (!full || pop_ok);

   assign count = count_reg;
   assign head  = head_reg;

   always_comb begin
      rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
      count_next  = count_reg + CW'(push_ok) - CW'(pop_ok);
      remain      = count_reg - CW'(pop_ok);
      head_next   = head_reg;
      if (remain != '0)
         head_next = mem[rd_ptr_next];
      else if (push_ok)
         head_next = push_data;
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         head_reg   <= head_next;
      end
   end

endmodule

// File: rtl/parity_rx_channel.sv
// Parity/sequence-checking receive channel: capture stage, check stage and an
// output FIFO with saturating error counters and a sticky overflow flag.
module parity_rx_channel import chan_pkg::*; #(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int PARITY_ODD = PAR_EVEN,
   parameter int SEQ_CHECK  = 1,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = 8
) (
   input  logic                   clk,
   input  logic                   clr_n,
   parity_rx_channel_if.slave     bus,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [CNT_W-1:0]       par_err_cnt,
   output logic [CNT_W-1:0]       seq_err_cnt,
   output logic                   overflow
);

   localparam logic PAR_BIT = (PARITY_ODD != 0);
   localparam logic SEQ_EN  = (SEQ_CHECK != 0);

   logic              cap_vld_reg;
   logic [DATA_W:0]   cap_word_reg;
   logic              armed_reg;
   logic [DATA_W-1:0] expected_reg;
   logic [CNT_W-1:0]  par_cnt_reg, par_cnt_next;
   logic [CNT_W-1:0]  seq_cnt_reg, seq_cnt_next;
   logic              overflow_reg;

   logic [DATA_W-1:0] cap_data;
   logic              parity_ok, good, bad, seq_break;
   logic              fifo_full, fifo_empty, pop;

   assign cap_data  = cap_word_reg[DATA_W-1:0];
   assign parity_ok = ((^cap_word_reg) == PAR_BIT);
   assign good      = cap_vld_reg && parity_ok;
   assign bad       = cap_vld_reg && !parity_ok;
   assign seq_break = good && SEQ_EN && armed_reg && (cap_data != expected_reg);
   assign pop       = bus.out_ready && !fifo_empty;

   always_comb begin
      par_cnt_next = par_cnt_reg;
      seq_cnt_next = seq_cnt_reg;
      if (bad)
         par_cnt_next = CNT_W'(sat_inc(32'(par_cnt_reg), CNT_W));
      if (seq_break)
         seq_cnt_next = CNT_W'(sat_inc(32'(seq_cnt_reg), CNT_W));
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cap_vld_reg  <= 1'b0;
         cap_word_reg <= '0;
         armed_reg    <= 1'b0;
         expected_reg <= '0;
         par_cnt_reg  <= '0;
         seq_cnt_reg  <= '0;
         overflow_reg <= 1'b0;
      end else begin
         cap_vld_reg <= bus.rx_stb;
         if (bus.rx_stb)
            cap_word_reg <= bus.rx_word;
         par_cnt_reg <= par_cnt_next;
         seq_cnt_reg <= seq_cnt_next;
         // Only words that pass parity advance the sequence tracker.
         if (good) begin
            expected_reg <= cap_data + DATA_W'(1);
            armed_reg    <= 1'b1;
         end
         if (good && fifo_full && !pop)
            overflow_reg <= 1'b1;
      end
   end

   chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .clr_n     (clr_n),
      .push      (good),
      .push_data (cap_data),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (bus.out_data)
   );

   assign bus.out_valid = !fifo_empty;
   assign par_err_cnt   = par_cnt_reg;
   assign seq_err_cnt   = seq_cnt_reg;
   assign overflow      = overflow_reg;

endmodule

// File: tb/tb_parity_rx_channel.sv
// Directed bench: an even-parity and an odd-parity channel share clock and reset.
module tb_parity_rx_channel;
   import chan_pkg::*;

   logic clk = 1'b0;
   logic clr_n;
   always #5 clk = ~clk;

   parity_rx_channel_if #(.DATA_W(9)) ife ();
   parity_rx_channel_if #(.DATA_W(9)) ifo ();

   logic [2:0] cnt_e, cnt_o;
   logic [7:0] par_e, seq_e, par_o, seq_o;
   logic       ovf_e, ovf_o;

   parity_rx_channel #(
      .DATA_W(9), .PARITY_ODD(PAR_EVEN), .SEQ_CHECK(1), .DEPTH(4), .CNT_W(8)
   ) dut_e (
      .clk(clk), .clr_n(clr_n), .bus(ife),
      .fifo_count(cnt_e), .par_err_cnt(par_e), .seq_err_cnt(seq_e), .overflow(ovf_e)
   );

   parity_rx_channel #(
      .DATA_W(9), .PARITY_ODD(PAR_ODD), .SEQ_CHECK(1), .DEPTH(4), .CNT_W(8)
   ) dut_o (
      .clk(clk), .clr_n(clr_n), .bus(ifo),
      .fifo_count(cnt_o), .par_err_cnt(par_o), .seq_err_cnt(seq_o), .overflow(ovf_o)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int got_e[$];
   int got_o[$];
   int exp_q[$];

   // Pops are recorded half a cycle before the edge that performs them.
   always @(negedge clk) begin
      if (clr_n && ife.out_valid && ife.out_ready) begin
         got_e.push_back(int'(ife.out_data));
         $display("even pop data=%0d count=%0d", ife.out_data, cnt_e);
      end
      if (clr_n && ifo.out_valid && ifo.out_ready) begin
         got_o.push_back(int'(ifo.out_data));
         $display("odd  pop data=%0d count=%0d", ifo.out_data, cnt_o);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_list(input string tag, input int got[$], input int exp[$]);
      check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
      foreach (exp[i])
         check($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
   endtask

   function automatic logic [9:0] mk_word(input int d, input bit odd);
      logic [8:0] v;
      v = d[8:0];
      return {(^v) ^ odd, v};
   endfunction

   task automatic send_e(input int d, input bit flip);
      ife.rx_stb  = 1'b1;
      ife.rx_word = mk_word(d, 1'b0) ^ {flip, 9'd0};
      tick();
   endtask

   task automatic send_o(input int d, input bit odd);
      ifo.rx_stb  = 1'b1;
      ifo.rx_word = mk_word(d, odd);
      tick();
   endtask

   task automatic do_reset();
      ife.rx_stb = 1'b0;
      ifo.rx_stb = 1'b0;
      clr_n = 1'b0;
      tick();
      clr_n = 1'b1;
      tick();
      got_e.delete();
      got_o.delete();
   endtask

   initial begin
      clr_n         = 1'b0;
      ife.rx_stb    = 1'b0;
      ife.rx_word   = '0;
      ife.out_ready = 1'b0;
      ifo.rx_stb    = 1'b0;
      ifo.rx_word   = '0;
      ifo.out_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(ife.out_valid), 0);
      check("rst_data",  32'(ife.out_data), 0);
      check("rst_count", 32'(cnt_e), 0);
      check("rst_par",   32'(par_e), 0);
      check("rst_seq",   32'(seq_e), 0);
      check("rst_ovf",   32'(ovf_e), 0);
      clr_n = 1'b1;
      tick();

      // In-order stream with latency check.
      ife.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send_e(i, 1'b0);
         if (i == 0) check("lat_first_edge", 32'(ife.out_valid), 0);
         if (i == 1) begin
            check("lat_second_edge", 32'(ife.out_valid), 1);
            check("lat_head", 32'(ife.out_data), 0);
         end
      end
      ife.rx_stb = 1'b0;
      repeat (4) tick();
      exp_q = {0, 1, 2, 3, 4, 5};
      check_list("inorder", got_e, exp_q);
      check("inorder_par", 32'(par_e), 0);
      check("inorder_seq", 32'(seq_e), 0);
      check("inorder_ovf", 32'(ovf_e), 0);

      // Parity error on word 3.
      do_reset();
      ife.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) send_e(i, i == 3);
      ife.rx_stb = 1'b0;
      repeat (4) tick();
      exp_q = {0, 1, 2, 4, 5};
      check_list("parerr", got_e, exp_q);
      check("parerr_par", 32'(par_e), 1);
      check("parerr_seq", 32'(seq_e), 1);

      // Skipped values 0,2,4.
      do_reset();
      ife.out_ready = 1'b1;
      send_e(0, 1'b0);
      send_e(2, 1'b0);
      send_e(4, 1'b0);
      ife.rx_stb = 1'b0;
      repeat (4) tick();
      exp_q = {0, 2, 4};
      check_list("skip", got_e, exp_q);
      check("skip_seq", 32'(seq_e), 2);
      check("skip_par", 32'(par_e), 0);

      // FIFO full with the consumer stalled.
      do_reset();
      ife.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send_e(i, 1'b0);
      ife.rx_stb = 1'b0;
      repeat (2) tick();
      check("full_count", 32'(cnt_e), 4);
      check("full_ovf",   32'(ovf_e), 1);
      check("full_head",  32'(ife.out_data), 0);
      check("full_valid", 32'(ife.out_valid), 1);
      ife.out_ready = 1'b1;
      repeat (5) tick();
      exp_q = {0, 1, 2, 3};
      check_list("drain", got_e, exp_q);
      check("drain_ovf",   32'(ovf_e), 1);
      check("drain_count", 32'(cnt_e), 0);

      // Push into a full FIFO on the same edge as a pop.
      do_reset();
      ife.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_e(i, 1'b0);
      send_e(4, 1'b0);
      check("simul_pre_count", 32'(cnt_e), 4);
      ife.rx_stb    = 1'b0;
      ife.out_ready = 1'b1;
      tick();
      check("simul_count", 32'(cnt_e), 4);
      check("simul_ovf",   32'(ovf_e), 0);
      repeat (5) tick();
      exp_q = {0, 1, 2, 3, 4};
      check_list("simul", got_e, exp_q);
      check("simul_ovf_end", 32'(ovf_e), 0);

      // Asynchronous reset between edges, with a bad word still in capture.
      do_reset();
      ife.out_ready = 1'b0;
      send_e(0, 1'b0);
      send_e(5, 1'b0);
      send_e(7, 1'b1);
      ife.rx_stb = 1'b0;
      check("mid_seq_pre",   32'(seq_e), 1);
      check("mid_count_pre", 32'(cnt_e), 2);
      #2;
      clr_n = 1'b0;
      #1;
      check("async_valid", 32'(ife.out_valid), 0);
      check("async_data",  32'(ife.out_data), 0);
      check("async_count", 32'(cnt_e), 0);
      check("async_seq",   32'(seq_e), 0);
      check("async_par",   32'(par_e), 0);
      check("async_ovf",   32'(ovf_e), 0);
      tick();
      clr_n = 1'b1;
      tick();
      tick();
      check("inflight_par",   32'(par_e), 0);
      check("inflight_count", 32'(cnt_e), 0);
      got_e.delete();
      got_o.delete();

      // Odd parity with expected-value wrap, then an even-parity word rejected.
      ifo.out_ready = 1'b1;
      send_o(510, 1'b1);
      send_o(511, 1'b1);
      send_o(0, 1'b1);
      send_o(1, 1'b0);
      ifo.rx_stb = 1'b0;
      repeat (4) tick();
      exp_q = {510, 511, 0};
      check_list("wrap", got_o, exp_q);
      check("wrap_seq", 32'(seq_o), 0);
      check("wrap_par", 32'(par_o), 1);
      check("wrap_ovf", 32'(ovf_o), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/parity_rx_channel.md
Name: parity_rx_channel

Overview:
- Parametrised successor to the 10-bit transmit/receive parity channel.
- Accepts strobed parity-protected words from a transmitter and checks parity (even or odd), checking as well that consecutive words form an incrementing sequence.
- Buffers good words in a small FIFO with a valid/ready output handshake.
- Keeps saturating error counters so the bench can see missed values directly.

Parameters:
- DATA_W, 9, payload width; rx_word is DATA_W+1 bits, MSB = parity bit.
- PARITY_ODD, 0, 0 = even parity over {parity,data}; 1 = odd parity.
- SEQ_CHECK, 1, 1 = flag good words that are not previous good word + 1.
- DEPTH, 4, output FIFO depth in words; power of two, >= 2.
- CNT_W, 8, width of each error counter.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- rx_stb  in  1  rx_word is valid this cycle.
- rx_word  in  DATA_W+1  {parity, data}.
- out_valid  out  1  FIFO head word available.
- out_ready  in  1  consumer accepts head when out_valid=1.
- out_data  out  DATA_W  FIFO head payload.
- fifo_count  out  $clog2(DEPTH)+1  words held.
- par_err_cnt  out  CNT_W  parity failures, saturating.
- seq_err_cnt  out  CNT_W  sequence breaks, saturating.
- overflow  out  1  sticky: a good word was dropped because the FIFO was full.

Behaviour:
- Reset:
  - clr_n low clears all state immediately, regardless of clk.
  - out_valid=0, out_data=0, fifo_count=0, both counters=0, overflow=0.
  - Capture stage empty; sequence tracker "unarmed".
- Stage 1 (capture): at an edge with rx_stb=1, rx_word is registered and cap_vld is set. cap_vld is a one-cycle pulse per strobe. Back-to-back strobes are allowed, one word per cycle.
- Stage 2 (check), on the edge after capture:
  - ok = (^rx_word) == PARITY_ODD.
  - ok=0: word dropped; par_err_cnt += 1 unless all-ones; tracker untouched.
  - ok=1 and SEQ_CHECK=1 and tracker armed and data != expected: seq_err_cnt += 1 (saturating); word still pushed.
  - ok=1: expected <= data+1 mod 2^DATA_W; tracker armed. The first good word after reset never flags.
  - ok=1: word pushed to FIFO if not full, else dropped and overflow <= 1 (cleared only by reset).
- Latency: strobe sampled at edge E -> pushed at edge E+1 -> out_valid high after E+1 when the FIFO was empty. out_data is registered from the FIFO head, not combinational from rx_word.
- Pop: at an edge with out_valid && out_ready. out_valid/out_data update the same edge. out_ready while out_valid=0 is ignored.
- Simultaneous push and pop:
  - Count unchanged.
  - When full, the pop frees a slot and the push succeeds: no overflow.
  - When empty, the push is ordinary, since out_valid was 0 and no pop occurs.
- Wrap-around:
  - FIFO pointers wrap mod DEPTH.
  - Expected value wraps, e.g. DATA_W=9: 511 followed by 0 is in sequence.
- Reset mid-operation: an in-flight captured word is discarded; no counter increments from it.
- fifo_count is registered and equals the number of stored words; it never exceeds DEPTH.

Decomposition:
- Shared package chan_pkg:
  - PAR_EVEN=0, PAR_ODD=1 constants.
  - Default DATA_W=9.
  - Saturating-increment function.
- One sub-module: chan_fifo.
  - Parameters DATA_W, DEPTH.
  - Synchronous FIFO with push/pop/full/empty/count, async active-low clr_n.
  - Registered head output.
- Capture, parity and sequence logic stay in parity_rx_channel.

Test Plan:
- Reset then in-order stream: even parity, words 0..5 with correct parity, one per cycle, out_ready=1 -> out_data 0,1,2,3,4,5; out_valid rises 2 edges after the first strobe; both counters 0; overflow 0.
- Parity error: word 3 sent with parity bit flipped among 0..5 -> out_data 0,1,2,4,5; par_err_cnt=1; seq_err_cnt=1 (4 after 2); word 3 never appears.
- Slow-clock skip: transmitter count advances faster than strobes, words 0,2,4 -> seq_err_cnt=2; par_err_cnt=0; all three words delivered.
- FIFO full: DEPTH=4, out_ready=0, 6 good words -> fifo_count=4, overflow=1, out_data=0. Then out_ready=1 -> 0,1,2,3 drained; overflow stays 1.
- Full with simultaneous pop: FIFO full, out_ready=1 and a new strobe -> count stays 4, overflow stays 0, new word delivered last.
- Async reset mid-stream and wrap: clr_n low between clock edges -> outputs 0 before the next edge. After release, PARITY_ODD=1, words 510, 511, 0 -> seq_err_cnt=0.
